// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM elastic stage: occupancy states, default payload
// layout and a helper that sizes the packed payload for any datapath width.
package ex_mem_pkg;

  localparam int DEF_DATA_LEN = 32;
  localparam int DEF_ADDR_LEN = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Field order here is the bit order used when the top packs its inputs.
  typedef struct packed {
    logic                    wb_en;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic [DEF_DATA_LEN-1:0] alu_res;
    logic [DEF_DATA_LEN-1:0] val_rm;
    logic [DEF_ADDR_LEN-1:0] dest;
    logic                    n_stat;
  } payload_t;

  function automatic int payload_w(input int data_len, input int addr_len);
    return 3 + 2 * data_len + addr_len + 1;
  endfunction

  localparam int PAYLOAD_W = payload_w(DEF_DATA_LEN, DEF_ADDR_LEN);

endpackage

// File: rtl/ex_mem_skid_buffer.sv
// Generic valid/ready buffer: two slots with a registered in_ready when
// EX_MEM_SKID_EN is defined, otherwise a single slot with pass-through ready.
module skid_buffer
  import ex_mem_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             accept;
  logic             pop;

`ifdef EX_MEM_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  // Ready depends only on the state register, so no path from out_ready.
  assign in_ready = (state_q != FULL) & ~rst;
`else
  assign in_ready = (~out_valid | out_ready) & ~rst;
`endif

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = (state_q == FULL) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef EX_MEM_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
`ifdef EX_MEM_SKID_EN
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
`else
          // Accept in ONE implies the head is being popped in the same cycle.
          if (accept) begin
            main_d = in_data;
          end else if (pop) begin
            state_d = EMPTY;
          end
`endif
        end
`ifdef EX_MEM_SKID_EN
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
`ifdef EX_MEM_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef EX_MEM_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// Elastic EX->MEM stage: packs the EX payload into the skid buffer and gates the
// WB/MEM control bits to zero whenever no valid head is presented.
// Optional 2-slot skid behaviour is selected with `define EX_MEM_SKID_EN.
module ex_mem_pipe_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_LEN             = 32,
  parameter int ADDRESS_LEN_REG_FILE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            WB_EN_in,
  input  logic                            MEM_R_EN_in,
  input  logic                            MEM_W_EN_in,
  input  logic [DATA_LEN-1:0]             ALU_Res_in,
  input  logic [DATA_LEN-1:0]             Val_Rm_in,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] Dest_in,
  input  logic                            N_stat_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            WB_EN,
  output logic                            MEM_R_EN,
  output logic                            MEM_W_EN,
  output logic [DATA_LEN-1:0]             ALU_Res,
  output logic [DATA_LEN-1:0]             Val_Rm,
  output logic [ADDRESS_LEN_REG_FILE-1:0] Dest,
  output logic                            N_stat,
  output logic [1:0]                      occupancy
);

  localparam int W = payload_w(DATA_LEN, ADDRESS_LEN_REG_FILE);

  logic [W-1:0] in_pl;
  logic [W-1:0] out_pl;
  logic [2:0]   ctrl_raw;
  logic [2:0]   ctrl_gated;

  assign in_pl = {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU_Res_in, Val_Rm_in, Dest_in, N_stat_in};

  skid_buffer #(
    .WIDTH(W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pl),
    .occupancy(occupancy)
  );

  assign {ctrl_raw, ALU_Res, Val_Rm, Dest, N_stat} = out_pl;

  // Stale slot contents after a flush must never issue a write or load.
  for (genvar gi = 0; gi < 3; gi++) begin : g_bubble
    assign ctrl_gated[gi] = ctrl_raw[gi] & out_valid;
  end

  assign {WB_EN, MEM_R_EN, MEM_W_EN} = ctrl_gated;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench for ex_mem_pipe_stage: a queue of accepted payloads is the
// reference; a monitor compares the DUT head, ready and occupancy every cycle.
module tb_ex_mem_pipe_stage;
  import ex_mem_pkg::*;

`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, N_stat_in;
  logic [31:0] ALU_Res_in, Val_Rm_in;
  logic [3:0]  Dest_in;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, N_stat;
  logic [31:0] ALU_Res, Val_Rm;
  logic [3:0]  Dest;
  logic [1:0]  occupancy;

  always #5 clk = ~clk;

  ex_mem_pipe_stage #(.DATA_LEN(32), .ADDRESS_LEN_REG_FILE(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
    .ALU_Res_in(ALU_Res_in), .Val_Rm_in(Val_Rm_in), .Dest_in(Dest_in), .N_stat_in(N_stat_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .N_stat(N_stat),
    .occupancy(occupancy)
  );

  payload_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic payload_t cur_in();
    payload_t p;
    p.wb_en    = WB_EN_in;
    p.mem_r_en = MEM_R_EN_in;
    p.mem_w_en = MEM_W_EN_in;
    p.alu_res  = ALU_Res_in;
    p.val_rm   = Val_Rm_in;
    p.dest     = Dest_in;
    p.n_stat   = N_stat_in;
    return p;
  endfunction

  // Expected ready from the capacity rule: room in the FIFO, or (single slot)
  // the head leaving this cycle.
  function automatic bit exp_ready();
    if (rst) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  // Monitor: compare DUT against the reference away from the clock edge.
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(exp_ready()));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("head_ctrl", 64'({WB_EN, MEM_R_EN, MEM_W_EN}),
          64'({q[0].wb_en, q[0].mem_r_en, q[0].mem_w_en}));
      chk("head_alu", 64'(ALU_Res), 64'(q[0].alu_res));
      chk("head_rm", 64'(Val_Rm), 64'(q[0].val_rm));
      chk("head_dest_n", 64'({Dest, N_stat}), 64'({q[0].dest, q[0].n_stat}));
    end else begin
      chk("bubble_ctrl", 64'({WB_EN, MEM_R_EN, MEM_W_EN}), 64'(0));
      chk("data_known", 64'($isunknown({ALU_Res, Val_Rm, Dest, N_stat})), 64'(0));
    end
  end

  // Reference update at the active edge: flush/reset drop everything,
  // otherwise pop the head if consumed and append the accepted entry.
  always @(posedge clk) begin
    bit acc, pp;
    acc = in_valid && exp_ready();
    pp  = (q.size() != 0) && out_ready;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(cur_in());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input bit [2:0] ctrl, input logic [31:0] alu,
                        input logic [3:0] d);
    in_valid = v;
    {WB_EN_in, MEM_R_EN_in, MEM_W_EN_in} = ctrl;
    ALU_Res_in = alu;
    Val_Rm_in  = $urandom;
    Dest_in    = d;
    N_stat_in  = alu[31];
  endtask

  // Producer holds an entry until the stage accepts it.
  task automatic send_hold(input logic [31:0] alu, input logic [3:0] d);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    set_in(1'b1, 3'(($urandom % 7) + 1), alu, d);
    while (!done && n < 50) begin
      @(negedge clk);
      done = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL send_hold: entry %h never accepted within %0d cycles", alu, n);
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, 3'b111, 32'hDEAD_BEEF, 4'hF);
    repeat (3) step();
    rst = 1'b0;
    in_valid = 1'b0;
    step();

    // Streaming back-to-back entries.
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 3'b100, 32'(i), 4'(i));
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Stall fill, then release with a held third entry.
    out_ready = 1'b0;
    send_hold(32'hA, 4'd10);
    fork
      begin
        send_hold(32'hB, 4'd11);
        send_hold(32'hC, 4'd12);
      end
      begin
        repeat (4) step();
        out_ready = 1'b1;
      end
    join
    repeat (4) step();

    // Flush with the stage stalled and a new entry offered.
    out_ready = 1'b0;
    send_hold(32'h11, 4'd1);
`ifdef EX_MEM_SKID_EN
    send_hold(32'h22, 4'd2);
`endif
    set_in(1'b1, 3'b111, 32'h33, 4'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    step();

    // Bubble with control bits asserted on an invalid input.
    out_ready = 1'b1;
    set_in(1'b0, 3'b001, 32'h44, 4'd4);
    repeat (3) step();

    // Randomised traffic with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom % 64) == 0;
      flush = ($urandom % 20) == 0;
      out_ready = ($urandom % 4) != 0;
      set_in(1'($urandom % 2), 3'($urandom), $urandom, 4'($urandom));
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
